// File: rtl/avmem_pkg.sv
// Shared types and defaults for the Avalon-MM memory responder.
// Holds the FSM state enum, default geometry and counter width.
package avmem_pkg;

    localparam int AW_DEF = 10;
    localparam int WAIT_DEF = 2;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } state_t;

endpackage

// File: rtl/avmem_ram.sv
// Single-port synchronous word array with per-byte write enables.
// Read data is registered and only updated when re is high.
module avmem_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave memory with a fixed number of wait states per transfer.
// Define AVMEM_BYTEENABLE_EN to honour byteenable on writes.
module avalon_mem_responder
    import avmem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int WAIT_CYCLES = WAIT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        proto_err
);

    localparam logic [CNT_W-1:0] WC = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t state;
    logic [CNT_W-1:0] cnt;
    logic is_wr;
    logic rd_zero;
    logic [31:0] ram_q;

    logic req;
    logic oor;
    logic [AW-1:0] idx;
    logic [3:0] wbe;
    logic go_acc;
    logic wr_now;
    logic rd_load;
    logic ram_we;

    assign req = read | write;
    assign oor = |(address >> (AW + 2));
    assign idx = address[AW+1:2];

`ifdef AVMEM_BYTEENABLE_EN
    assign wbe = byteenable;
`else
    logic unused_be;
    assign unused_be = &{1'b0, byteenable};
    assign wbe = 4'hF;
`endif

    // Entering ACCESS: straight from IDLE when there are no wait states.
    assign go_acc = req
        && ((state == IDLE && WAIT_CYCLES == 0)
         || (state == WAIT && cnt <= ONE));
    assign wr_now = (state == IDLE) ? write : is_wr;
    assign rd_load = go_acc && !wr_now && reset_n;
    assign ram_we = (state == ACCESS) && is_wr && !oor && reset_n;

    avmem_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .addr  (idx),
        .we    (ram_we),
        .be    (wbe),
        .wdata (writedata),
        .re    (rd_load),
        .rdata (ram_q)
    );

    // Out-of-range reads and reset both present zero without touching the array.
    assign readdata = rd_zero ? 32'h0 : ram_q;

    always_comb begin
        waitrequest = 1'b0;
        unique case (state)
            IDLE:    waitrequest = req;
            WAIT:    waitrequest = 1'b1;
            default: waitrequest = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            is_wr     <= 1'b0;
            proto_err <= 1'b0;
            rd_zero   <= 1'b1;
        end else begin
            if (rd_load) begin
                rd_zero <= oor;
            end
            unique case (state)
                IDLE: begin
                    if (req) begin
                        is_wr <= write;
                        if (read && write) begin
                            proto_err <= 1'b1;
                        end
                        if (WAIT_CYCLES == 0) begin
                            state <= ACCESS;
                        end else begin
                            state <= WAIT;
                            cnt   <= WC;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        proto_err <= 1'b1;
                    end else if (cnt <= ONE) begin
                        state <= ACCESS;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                ACCESS: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Self-checking bench for avalon_mem_responder (WAIT_CYCLES=2 and 0 instances).
// Reads are checked against a word-array model of the memory.
module tb_avalon_mem_responder;

    logic clk = 1'b0;
    logic reset_n;
    logic        rd_s   [2];
    logic        wr_s   [2];
    logic [31:0] addr_s [2];
    logic [3:0]  be_s   [2];
    logic [31:0] wd_s   [2];
    logic [31:0] rdd_s  [2];
    logic        wreq_s [2];
    logic        perr_s [2];

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] mem_m [2][1024];

    always #5 clk = ~clk;

    avalon_mem_responder #(.AW(10), .WAIT_CYCLES(2)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (addr_s[0]),
        .read        (rd_s[0]),
        .write       (wr_s[0]),
        .byteenable  (be_s[0]),
        .writedata   (wd_s[0]),
        .readdata    (rdd_s[0]),
        .waitrequest (wreq_s[0]),
        .proto_err   (perr_s[0])
    );

    avalon_mem_responder #(.AW(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (addr_s[1]),
        .read        (rd_s[1]),
        .write       (wr_s[1]),
        .byteenable  (be_s[1]),
        .writedata   (wd_s[1]),
        .readdata    (rdd_s[1]),
        .waitrequest (wreq_s[1]),
        .proto_err   (perr_s[1])
    );

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = nw;
`ifdef AVMEM_BYTEENABLE_EN
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
`endif
        return r;
    endfunction

    task automatic model_write(input int k, input logic [31:0] a,
                               input logic [3:0] be, input logic [31:0] d);
        if (a[31:12] == 20'h0)
            mem_m[k][a[11:2]] = merge(mem_m[k][a[11:2]], d, be);
    endtask

    function automatic logic [31:0] model_read(input int k, input logic [31:0] a);
        if (a[31:12] != 20'h0) return 32'h0;
        return mem_m[k][a[11:2]];
    endfunction

    // Starts at a negedge, returns at the negedge after the ACCESS cycle.
    task automatic xfer(input int k, input logic r, input logic w,
                        input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d,
                        output logic [31:0] rdat, output int nw);
        rd_s[k] = r;
        wr_s[k] = w;
        addr_s[k] = a;
        be_s[k] = be;
        wd_s[k] = d;
        nw = 0;
        #1;
        while (wreq_s[k] === 1'b1 && nw < 40) begin
            nw++;
            @(negedge clk);
            #1;
        end
        rdat = rdd_s[k];
        @(negedge clk);
        rd_s[k] = 1'b0;
        wr_s[k] = 1'b0;
        if (w) model_write(k, a, be, d);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd_s[k] = 1'b0;
            wr_s[k] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd_s[k] = 1'b0;
            wr_s[k] = 1'b0;
            addr_s[k] = 32'h0;
            be_s[k] = 4'hF;
            wd_s[k] = 32'h0;
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (wreq_s[0] !== 1'b0) $display("FAIL reset_wreq: got %b want 0", wreq_s[0]);
        else n_pass++;
        n_chk++;
        if (rdd_s[0] !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdd_s[0]);
        else n_pass++;
        n_chk++;
        if (perr_s[0] !== 1'b0) $display("FAIL reset_perr: got %b want 0", perr_s[0]);
        else n_pass++;
        n_chk++;
        if (rdd_s[1] !== 32'h0) $display("FAIL reset_rdata0: got %h want 0", rdd_s[1]);
        else n_pass++;
        rd_s[0] = 1'b1;
        #1;
        n_chk++;
        if (wreq_s[0] !== 1'b1) $display("FAIL reset_wreq_req: got %b want 1", wreq_s[0]);
        else n_pass++;
        rd_s[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] rdat;
        int nw;
        xfer(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rdat, nw);
        n_chk++;
        if (nw !== 3) $display("FAIL basic_wr_wait: got %0d want 3", nw);
        else n_pass++;
        xfer(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, rdat, nw);
        n_chk++;
        if (nw !== 3) $display("FAIL basic_rd_wait: got %0d want 3", nw);
        else n_pass++;
        n_chk++;
        if (rdat !== 32'hDEADBEEF) $display("FAIL basic_rd: got %h want deadbeef", rdat);
        else n_pass++;
    endtask

    task automatic test_byteenable();
        logic [31:0] rdat;
        logic [31:0] exp;
        int nw;
        xfer(0, 1'b0, 1'b1, 32'h10, 4'b0101, 32'h11223344, rdat, nw);
        xfer(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, rdat, nw);
`ifdef AVMEM_BYTEENABLE_EN
        exp = 32'hDE22BE44;
`else
        exp = 32'h11223344;
`endif
        n_chk++;
        if (rdat !== exp) $display("FAIL byteenable: got %h want %h", rdat, exp);
        else n_pass++;
        xfer(0, 1'b0, 1'b1, 32'h10, 4'b0000, 32'h99999999, rdat, nw);
        xfer(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, rdat, nw);
        exp = model_read(0, 32'h10);
        n_chk++;
        if (rdat !== exp) $display("FAIL be_zero: got %h want %h", rdat, exp);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] rdat;
        int nw;
        xfer(0, 1'b0, 1'b1, 32'h0, 4'hF, 32'hA5A50F0F, rdat, nw);
        xfer(0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, rdat, nw);
        n_chk++;
        if (rdat !== 32'h0) $display("FAIL oor_read: got %h want 0", rdat);
        else n_pass++;
        xfer(0, 1'b0, 1'b1, 32'h1000, 4'hF, 32'h12345678, rdat, nw);
        xfer(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, rdat, nw);
        n_chk++;
        if (rdat !== 32'hA5A50F0F) $display("FAIL oor_write: got %h want a5a50f0f", rdat);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [31:0] rdat;
        logic [31:0] exp;
        int nw;
        xfer(0, 1'b0, 1'b1, 32'h30, 4'hF, 32'h0BADF00D, rdat, nw);
        rd_s[0] = 1'b1;
        addr_s[0] = 32'h30;
        @(negedge clk);
        @(negedge clk);
        rd_s[0] = 1'b0;
        @(negedge clk);
        #1;
        n_chk++;
        if (perr_s[0] !== 1'b1) $display("FAIL abort_rd_perr: got %b want 1", perr_s[0]);
        else n_pass++;
        n_chk++;
        if (wreq_s[0] !== 1'b0) $display("FAIL abort_rd_idle: got %b want 0", wreq_s[0]);
        else n_pass++;
        do_reset();
        wr_s[0] = 1'b1;
        addr_s[0] = 32'h30;
        be_s[0] = 4'hF;
        wd_s[0] = 32'hFFFFFFFF;
        @(negedge clk);
        @(negedge clk);
        wr_s[0] = 1'b0;
        @(negedge clk);
        #1;
        n_chk++;
        if (perr_s[0] !== 1'b1) $display("FAIL abort_wr_perr: got %b want 1", perr_s[0]);
        else n_pass++;
        @(negedge clk);
        xfer(0, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0, rdat, nw);
        exp = model_read(0, 32'h30);
        n_chk++;
        if (rdat !== exp) $display("FAIL abort_wr_mem: got %h want %h", rdat, exp);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_rw_both();
        logic [31:0] rdat;
        logic [31:0] prev;
        logic [31:0] exp;
        int nw;
        xfer(0, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0, prev, nw);
        xfer(0, 1'b1, 1'b1, 32'h34, 4'hF, 32'h5A5A1234, rdat, nw);
        n_chk++;
        if (nw !== 3) $display("FAIL rw_wait: got %0d want 3", nw);
        else n_pass++;
        n_chk++;
        if (rdat !== prev) $display("FAIL rw_rdata_hold: got %h want %h", rdat, prev);
        else n_pass++;
        n_chk++;
        if (perr_s[0] !== 1'b1) $display("FAIL rw_perr: got %b want 1", perr_s[0]);
        else n_pass++;
        xfer(0, 1'b1, 1'b0, 32'h34, 4'hF, 32'h0, rdat, nw);
        exp = model_read(0, 32'h34);
        n_chk++;
        if (rdat !== exp) $display("FAIL rw_mem: got %h want %h", rdat, exp);
        else n_pass++;
    endtask

    task automatic test_reset_midwrite();
        logic [31:0] rdat;
        logic [31:0] exp;
        int nw;
        xfer(0, 1'b0, 1'b1, 32'h20, 4'hF, 32'h20202020, rdat, nw);
        xfer(0, 1'b1, 1'b0, 32'h34, 4'hF, 32'h0, rdat, nw);
        wr_s[0] = 1'b1;
        addr_s[0] = 32'h20;
        be_s[0] = 4'hF;
        wd_s[0] = 32'hDDDDDDDD;
        @(negedge clk);
        reset_n = 1'b0;
        wr_s[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_chk++;
        if (perr_s[0] !== 1'b0) $display("FAIL rstmid_perr: got %b want 0", perr_s[0]);
        else n_pass++;
        n_chk++;
        if (wreq_s[0] !== 1'b0) $display("FAIL rstmid_idle: got %b want 0", wreq_s[0]);
        else n_pass++;
        n_chk++;
        if (rdd_s[0] !== 32'h0) $display("FAIL rstmid_rdata: got %h want 0", rdd_s[0]);
        else n_pass++;
        @(negedge clk);
        xfer(0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, rdat, nw);
        n_chk++;
        if (rdat !== 32'h20202020) $display("FAIL rstmid_nowrite: got %h want 20202020", rdat);
        else n_pass++;
        xfer(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, rdat, nw);
        exp = model_read(0, 32'h10);
        n_chk++;
        if (rdat !== exp) $display("FAIL rstmid_keep: got %h want %h", rdat, exp);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rdat;
        logic [31:0] exp;
        logic [31:0] a;
        int nw;
        for (int w = 0; w < 16; w++)
            xfer(0, 1'b0, 1'b1, 32'(w * 4), 4'hF, $urandom, rdat, nw);
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
            if ($urandom_range(0, 2) == 0) begin
                xfer(0, 1'b0, 1'b1, a, 4'($urandom_range(0, 15)), $urandom, rdat, nw);
            end else begin
                xfer(0, 1'b1, 1'b0, a, 4'hF, 32'h0, rdat, nw);
                exp = model_read(0, a);
                n_chk++;
                if (rdat !== exp) $display("FAIL rand_rd[%0d] a=%h: got %h want %h", i, a, rdat, exp);
                else n_pass++;
            end
            n_chk++;
            if (nw !== 3) $display("FAIL rand_wait[%0d]: got %0d want 3", i, nw);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rdat;
        logic [31:0] exp;
        int nw;
        for (int w = 0; w < 3; w++) begin
            xfer(1, 1'b0, 1'b1, 32'(w * 4), 4'hF, $urandom, rdat, nw);
            n_chk++;
            if (nw !== 1) $display("FAIL b2b_wr_wait[%0d]: got %0d want 1", w, nw);
            else n_pass++;
        end
        rd_s[1] = 1'b1;
        for (int w = 0; w < 3; w++) begin
            addr_s[1] = 32'(w * 4);
            #1;
            n_chk++;
            if (wreq_s[1] !== 1'b1) $display("FAIL b2b_idle_wreq[%0d]: got %b want 1", w, wreq_s[1]);
            else n_pass++;
            @(negedge clk);
            #1;
            n_chk++;
            if (wreq_s[1] !== 1'b0) $display("FAIL b2b_acc_wreq[%0d]: got %b want 0", w, wreq_s[1]);
            else n_pass++;
            exp = model_read(1, 32'(w * 4));
            n_chk++;
            if (rdd_s[1] !== exp) $display("FAIL b2b_rd[%0d]: got %h want %h", w, rdd_s[1], exp);
            else n_pass++;
            @(negedge clk);
        end
        rd_s[1] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_byteenable();
        test_out_of_range();
        test_abort();
        test_rw_both();
        test_reset_midwrite();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/avalon_mem_responder.md
AVALON_MEM_RESPONDER -- requirements
Module: avalon_mem_responder

Interface
REQ-001 The block SHALL have these parameters:
- AW, default 10, log2 of memory depth in 32-bit words.
- WAIT_CYCLES, default 2, extra wait states per transfer (0..15).
REQ-002 The block SHALL have these ports (clk and reset_n first):
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- address  in  32  byte address from the CPU initiator.
- read  in  1  read request.
- write  in  1  write request.
- byteenable  in  4  byte lanes for writes; bit0 = bits 7:0.
- writedata  in  32  write data.
- readdata  out  32  read data, valid when waitrequest is low and read is high.
- waitrequest  out  1  high stalls the initiator.
- proto_err  out  1  sticky protocol-violation flag.

Function
REQ-003 The word index SHALL be address[AW+1:2]; address[1:0] SHALL be ignored.
REQ-004 An address with any bit above AW+1 set is out-of-range: reads SHALL return 0 and writes SHALL be dropped.
REQ-005 The FSM SHALL have three states:
- IDLE: waitrequest = read|write (combinational). If read|write, go to WAIT and load the counter with WAIT_CYCLES.
- WAIT: waitrequest = 1. Decrement the counter; at 0, go to ACCESS.
- ACCESS: waitrequest = 0. Return to IDLE next cycle.
REQ-006 A transfer first sampled in cycle N SHALL complete, with waitrequest low, in cycle N+WAIT_CYCLES+1; waitrequest is high in cycles N..N+WAIT_CYCLES.
REQ-007 readdata SHALL be registered, loaded on the WAIT->ACCESS edge from the indexed word, and held stable until the next read completes.
REQ-008 A write SHALL update the array on the rising edge that ends the ACCESS cycle, using the address and writedata present in ACCESS.
REQ-009 If the initiator drops read|write while in WAIT, the FSM SHALL return to IDLE next cycle, SHALL perform no write, and SHALL set proto_err.
REQ-010 If read and write are both high when sampled in IDLE, the transfer SHALL be treated as a write, readdata SHALL be unchanged, and proto_err SHALL be set.
REQ-011 A read after a write to the same word SHALL return the newly written data; no stale bypass is permitted.
REQ-012 Back-to-back requests SHALL be accepted: after ACCESS, an IDLE cycle with read|write high SHALL restart the WAIT sequence.

Reset
REQ-013 While reset_n is low at a clock edge, the block SHALL enter IDLE, clear the counter, readdata and proto_err, and abort any in-flight transfer without writing.
REQ-014 Memory contents SHALL NOT be cleared by reset.
REQ-015 waitrequest after reset SHALL equal read|write, as defined for IDLE.

Configuration
REQ-016 With macro AVMEM_BYTEENABLE_EN defined, writes SHALL update only the byte lanes whose byteenable bit is 1; byteenable=4'b0000 SHALL leave the word unchanged.
REQ-017 Without AVMEM_BYTEENABLE_EN, byteenable SHALL be ignored and every write SHALL update the full word.

Structure
REQ-018 Package avmem_pkg SHALL hold the FSM state enum (IDLE, WAIT, ACCESS), the default AW and WAIT_CYCLES values, and the counter width constant (4).
REQ-019 The storage SHALL be a sub-module avmem_ram: a single-port synchronous array with per-byte write enables, read data registered.

Verification
REQ-020 Reset, then a write to 0x00000010 with data 0xDEADBEEF and byteenable 4'hF, WAIT_CYCLES=2 -> waitrequest is high for 3 cycles, then low for 1; a following read of 0x10 returns 0xDEADBEEF.
REQ-021 With AVMEM_BYTEENABLE_EN, word 0x10 = 0xDEADBEEF, write 0x11223344 with byteenable 4'b0101 -> reading 0x10 returns 0xDE22BE44. Without the macro -> the read returns 0x11223344.
REQ-022 Read of 0x00001000 with AW=10 -> readdata = 0x00000000. A write to the same address changes nothing, checked by reading word 0.
REQ-023 read drops after 1 WAIT cycle -> FSM in IDLE next cycle, proto_err=1, memory unchanged. Assert read and write together -> write performed, proto_err=1.
REQ-024 reset_n pulled low during WAIT of a write to 0x20 -> no write occurs, the FSM is in IDLE and proto_err=0. Contents of an earlier-written 0x10 survive.
REQ-025 WAIT_CYCLES=0 with back-to-back reads of 0x0, 0x4, 0x8 -> each completes 1 cycle after it is sampled, with one IDLE cycle between transfers.
